// File: rtl/noc_traffic_node_pkg.sv
// Shared NoC field layout, widths and flit builders for the traffic generator/checker node.
// Flit layout (MSB first): head/tail marker, src X/Y, dst X/Y, type, order, len, end marker, pad.
package noc_traffic_node_pkg;

  localparam int NOC_DATA_WIDTH     = 32;
  localparam int NOC_ID_X_WIDTH     = 3;
  localparam int NOC_ID_Y_WIDTH     = 3;
  localparam int NOC_TEST_PAT_WIDTH = 16;
  localparam int NOC_PAD_WIDTH      = 4;

  localparam logic [1:0] NOC_HEAD_H = 2'b11;
  localparam logic [1:0] NOC_HEAD_E = 2'b10;
  localparam logic [1:0] NOC_TAIL_H = 2'b01;
  localparam logic [1:0] NOC_TAIL_E = 2'b01;

  localparam int NOC_HDR_DST_X_LSB = 21;
  localparam int NOC_HDR_DST_X_MSB = NOC_HDR_DST_X_LSB + NOC_ID_X_WIDTH - 1;
  localparam int NOC_HDR_DST_Y_LSB = 18;
  localparam int NOC_HDR_DST_Y_MSB = NOC_HDR_DST_Y_LSB + NOC_ID_Y_WIDTH - 1;
  localparam int NOC_HDR_LEN_LSB   = 6;
  localparam int NOC_HDR_LEN_MSB   = NOC_HDR_LEN_LSB + 7;
  localparam int NOC_PAT_SEQ_LSB   = 8;

  function automatic logic [NOC_DATA_WIDTH-1:0] build_ctrl_flit(
    input logic [1:0]                mark_h,
    input logic [NOC_ID_X_WIDTH-1:0] src_x,
    input logic [NOC_ID_Y_WIDTH-1:0] src_y,
    input logic [NOC_ID_X_WIDTH-1:0] dst_x,
    input logic [NOC_ID_Y_WIDTH-1:0] dst_y,
    input logic [7:0]                len,
    input logic [1:0]                mark_e
  );
    return {mark_h, src_x, src_y, dst_x, dst_y, 2'b00, 2'b00, len, mark_e, {NOC_PAD_WIDTH{1'b0}}};
  endfunction

  function automatic logic [NOC_DATA_WIDTH-1:0] build_data_flit(input logic [7:0] seq, input logic [7:0] k);
    return {{(NOC_DATA_WIDTH - NOC_TEST_PAT_WIDTH){1'b1}}, seq, k};
  endfunction

  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/noc_traffic_node_rx_ctx.sv
// One virtual-channel receive context: tracks framing, destination and payload pattern
// of the packet in flight and emits a registered good or error pulse per event.
module noc_traffic_rx_ctx
  import noc_traffic_node_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID = 3'd0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID = 3'd0
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      flit_valid,
  input  logic [NOC_DATA_WIDTH-1:0] flit,
  input  logic                      is_header,
  input  logic                      is_tail,
  output logic                      pkt_good,
  output logic                      pkt_err
);

  localparam logic CTX_IDLE = 1'b0;
  localparam logic CTX_BODY = 1'b1;

  logic       ctx_state_r;
  logic       bad_r;
  logic       seq_known_r;
  logic [7:0] seq_r;
  logic [7:0] k_r;
  logic [7:0] len_r;
  logic       pkt_good_r;
  logic       pkt_err_r;
  logic       dest_bad_s;
  logic       data_bad_s;
  logic       unused_flit_s;

  assign dest_bad_s = (flit[NOC_HDR_DST_X_MSB:NOC_HDR_DST_X_LSB] != X_ID) ||
                      (flit[NOC_HDR_DST_Y_MSB:NOC_HDR_DST_Y_LSB] != Y_ID);
  // Until the first data flit arrives the sequence number is unknown, so only k is checked.
  assign data_bad_s = (flit[NOC_PAT_SEQ_LSB-1:0] != k_r) ||
                      (seq_known_r && (flit[NOC_TEST_PAT_WIDTH-1:NOC_PAT_SEQ_LSB] != seq_r));
  assign unused_flit_s = ^{flit[NOC_DATA_WIDTH-1:NOC_HDR_DST_X_MSB+1],
                           flit[NOC_HDR_DST_Y_LSB-1:NOC_TEST_PAT_WIDTH]};

  assign pkt_good = pkt_good_r;
  assign pkt_err  = pkt_err_r;

  // Per-VC packet tracking and verdict generation
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      ctx_state_r <= CTX_IDLE;
      bad_r       <= 1'b0;
      seq_known_r <= 1'b0;
      seq_r       <= 8'd0;
      k_r         <= 8'd0;
      len_r       <= 8'd0;
      pkt_good_r  <= 1'b0;
      pkt_err_r   <= 1'b0;
    end else begin
      pkt_good_r <= 1'b0;
      pkt_err_r  <= 1'b0;
      if (flit_valid) begin
        if (is_header) begin
          // A header inside a packet abandons the old one and restarts on the new header.
          pkt_err_r   <= (ctx_state_r == CTX_BODY);
          ctx_state_r <= CTX_BODY;
          bad_r       <= dest_bad_s;
          len_r       <= flit[NOC_HDR_LEN_MSB:NOC_HDR_LEN_LSB];
          k_r         <= 8'd0;
          seq_known_r <= 1'b0;
        end else if (ctx_state_r == CTX_IDLE) begin
          pkt_err_r <= 1'b1;
        end else if (is_tail) begin
          if (bad_r || (k_r != len_r)) begin
            pkt_err_r <= 1'b1;
          end else begin
            pkt_good_r <= 1'b1;
          end
          ctx_state_r <= CTX_IDLE;
        end else begin
          if (data_bad_s) begin
            bad_r <= 1'b1;
          end
          if (!seq_known_r) begin
            seq_r       <= flit[NOC_TEST_PAT_WIDTH-1:NOC_PAT_SEQ_LSB];
            seq_known_r <= 1'b1;
          end
          k_r <= k_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/noc_traffic_node.sv
// NoC endpoint traffic generator/checker: injects bursts of patterned packets round-robin
// over the VCs and checks every received packet, with saturating status counters.
module noc_traffic_node
  import noc_traffic_node_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID      = 3'd0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID      = 3'd0,
  parameter logic [NOC_ID_X_WIDTH-1:0] DEST_X_ID = 3'd0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] DEST_Y_ID = 3'd0,
  parameter int PAYLOAD_FLITS = 4,
  parameter int PKT_COUNT     = 8,
  parameter int VC_NUM        = 2,
  parameter int IDLE_GAP      = 0
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      send_start,
  input  logic                      rx_hold,
  output logic [VC_NUM-1:0]         sender_valid,
  input  logic [VC_NUM-1:0]         sender_ready,
  output logic [NOC_DATA_WIDTH-1:0] sender_flit,
  output logic                      sender_is_header,
  output logic                      sender_is_tail,
  input  logic [VC_NUM-1:0]         receive_valid,
  output logic [VC_NUM-1:0]         receive_ready,
  input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  output logic                      send_busy,
  output logic                      send_done,
  output logic [15:0]               pkt_sent_cnt,
  output logic [15:0]               pkt_recv_cnt,
  output logic [15:0]               err_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [15:0]       LAST_SEQ = 16'(PKT_COUNT - 1);
  localparam logic [7:0]        LAST_K   = 8'(PAYLOAD_FLITS - 1);
  localparam logic [7:0]        GAP_LOAD = 8'(IDLE_GAP - 1);
  localparam logic [2:0]        LAST_VC  = 3'(VC_NUM - 1);
  localparam logic [VC_NUM-1:0] VC_ONE   = VC_NUM'(1'b1);
  localparam logic [NOC_DATA_WIDTH-1:0] HEAD_FLIT =
    build_ctrl_flit(NOC_HEAD_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, 8'(PAYLOAD_FLITS), NOC_HEAD_E);
  localparam logic [NOC_DATA_WIDTH-1:0] TAIL_FLIT =
    build_ctrl_flit(NOC_TAIL_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, 8'(PAYLOAD_FLITS), NOC_TAIL_E);

  logic [2:0]                tx_state_r;
  logic [15:0]               seq_r;
  logic [7:0]                k_r;
  logic [7:0]                gap_r;
  logic [2:0]                vc_idx_r;
  logic [VC_NUM-1:0]         sender_valid_r;
  logic [NOC_DATA_WIDTH-1:0] sender_flit_r;
  logic                      sender_is_header_r;
  logic                      sender_is_tail_r;
  logic                      send_busy_r;
  logic                      send_done_r;
  logic [15:0]               pkt_sent_cnt_r;
  logic                      tx_fire_s;
  logic                      pkt_end_s;
  logic [2:0]                vc_next_s;

  assign tx_fire_s = |(sender_valid_r & sender_ready);
  assign vc_next_s = (vc_idx_r == LAST_VC) ? 3'd0 : vc_idx_r + 3'd1;
  // A packet is finished either on tail acceptance (no gap) or when the gap count runs out.
  assign pkt_end_s = ((tx_state_r == S_TAIL) && tx_fire_s && (IDLE_GAP == 0)) ||
                     ((tx_state_r == S_GAP) && (gap_r == 8'd0));

  // Sender FSM: one registered flit presented at a time, advanced on handshake
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      tx_state_r         <= S_IDLE;
      seq_r              <= 16'd0;
      k_r                <= 8'd0;
      gap_r              <= 8'd0;
      vc_idx_r           <= 3'd0;
      sender_valid_r     <= {VC_NUM{1'b0}};
      sender_flit_r      <= {NOC_DATA_WIDTH{1'b0}};
      sender_is_header_r <= 1'b0;
      sender_is_tail_r   <= 1'b0;
      send_busy_r        <= 1'b0;
      send_done_r        <= 1'b0;
      pkt_sent_cnt_r     <= 16'd0;
    end else begin
      send_done_r <= 1'b0;
      case (tx_state_r)
        S_IDLE: begin
          if (send_start) begin
            tx_state_r         <= S_HEAD;
            seq_r              <= 16'd0;
            vc_idx_r           <= 3'd0;
            sender_valid_r     <= VC_ONE;
            sender_flit_r      <= HEAD_FLIT;
            sender_is_header_r <= 1'b1;
            send_busy_r        <= 1'b1;
          end
        end
        S_HEAD: begin
          if (tx_fire_s) begin
            tx_state_r         <= S_DATA;
            k_r                <= 8'd0;
            sender_flit_r      <= build_data_flit(seq_r[7:0], 8'd0);
            sender_is_header_r <= 1'b0;
          end
        end
        S_DATA: begin
          if (tx_fire_s) begin
            if (k_r == LAST_K) begin
              tx_state_r       <= S_TAIL;
              sender_flit_r    <= TAIL_FLIT;
              sender_is_tail_r <= 1'b1;
            end else begin
              k_r           <= k_r + 8'd1;
              sender_flit_r <= build_data_flit(seq_r[7:0], k_r + 8'd1);
            end
          end
        end
        S_TAIL: begin
          if (tx_fire_s) begin
            pkt_sent_cnt_r <= sat_inc16(pkt_sent_cnt_r);
            if (IDLE_GAP != 0) begin
              tx_state_r       <= S_GAP;
              gap_r            <= GAP_LOAD;
              sender_valid_r   <= {VC_NUM{1'b0}};
              sender_flit_r    <= {NOC_DATA_WIDTH{1'b0}};
              sender_is_tail_r <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_r != 8'd0) begin
            gap_r <= gap_r - 8'd1;
          end
        end
        default: begin
          tx_state_r     <= S_IDLE;
          sender_valid_r <= {VC_NUM{1'b0}};
          send_busy_r    <= 1'b0;
        end
      endcase
      if (pkt_end_s) begin
        if (seq_r == LAST_SEQ) begin
          tx_state_r       <= S_IDLE;
          sender_valid_r   <= {VC_NUM{1'b0}};
          sender_flit_r    <= {NOC_DATA_WIDTH{1'b0}};
          sender_is_tail_r <= 1'b0;
          send_busy_r      <= 1'b0;
          send_done_r      <= 1'b1;
        end else begin
          tx_state_r         <= S_HEAD;
          seq_r              <= seq_r + 16'd1;
          vc_idx_r           <= vc_next_s;
          sender_valid_r     <= VC_ONE << vc_next_s;
          sender_flit_r      <= HEAD_FLIT;
          sender_is_header_r <= 1'b1;
          sender_is_tail_r   <= 1'b0;
        end
      end
    end
  end

  assign sender_valid     = sender_valid_r;
  assign sender_flit      = sender_flit_r;
  assign sender_is_header = sender_is_header_r;
  assign sender_is_tail   = sender_is_tail_r;
  assign send_busy        = send_busy_r;
  assign send_done        = send_done_r;
  assign pkt_sent_cnt     = pkt_sent_cnt_r;

  logic [VC_NUM-1:0] receive_ready_r;
  logic [VC_NUM-1:0] rx_fire_s;
  logic              rx_multi_s;
  logic              multi_err_r;
  logic [VC_NUM-1:0] ctx_good_s;
  logic [VC_NUM-1:0] ctx_err_s;
  logic [15:0]       pkt_recv_cnt_r;
  logic [15:0]       err_cnt_r;

  assign rx_fire_s  = receive_valid & receive_ready_r;
  assign rx_multi_s = multi_hot(8'(rx_fire_s));

  for (genvar v = 0; v < VC_NUM; v++) begin : g_rx_ctx
    noc_traffic_rx_ctx #(
      .X_ID (X_ID),
      .Y_ID (Y_ID)
    ) u_ctx (
      .noc_clk    (noc_clk),
      .noc_rst_n  (noc_rst_n),
      .flit_valid (rx_fire_s[v] & ~rx_multi_s),
      .flit       (receive_flit),
      .is_header  (receive_is_header),
      .is_tail    (receive_is_tail),
      .pkt_good   (ctx_good_s[v]),
      .pkt_err    (ctx_err_s[v])
    );
  end

  // Receive-side ready and shared saturating status counters
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      receive_ready_r <= {VC_NUM{1'b1}};
      multi_err_r     <= 1'b0;
      pkt_recv_cnt_r  <= 16'd0;
      err_cnt_r       <= 16'd0;
    end else begin
      receive_ready_r <= {VC_NUM{~rx_hold}};
      multi_err_r     <= rx_multi_s;
      if (|ctx_good_s) begin
        pkt_recv_cnt_r <= sat_inc16(pkt_recv_cnt_r);
      end
      // Only one flit lands per cycle, so at most one error source fires at a time.
      if ((|ctx_err_s) || multi_err_r) begin
        err_cnt_r <= sat_inc16(err_cnt_r);
      end
    end
  end

  assign receive_ready = receive_ready_r;
  assign pkt_recv_cnt  = pkt_recv_cnt_r;
  assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed self-checking bench for noc_traffic_node: loopback bursts, random backpressure,
// receiver framing/pattern/destination errors and async reset mid-burst.
module tb_noc_traffic_node;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        send_start = 1'b0;
  logic        rx_hold = 1'b0;
  logic [1:0]  sender_valid;
  logic [1:0]  sender_ready_s;
  logic [31:0] sender_flit;
  logic        sender_is_header;
  logic        sender_is_tail;
  logic [1:0]  receive_valid_s;
  logic [1:0]  receive_ready;
  logic [31:0] receive_flit_s;
  logic        receive_is_header_s;
  logic        receive_is_tail_s;
  logic        send_busy;
  logic        send_done;
  logic [15:0] pkt_sent_cnt;
  logic [15:0] pkt_recv_cnt;
  logic [15:0] err_cnt;

  logic        loop_en = 1'b0;
  logic        rand_mode = 1'b0;
  logic        mon_en = 1'b0;
  logic [1:0]  rand_bits = 2'b11;
  logic [1:0]  rx_valid_drv = 2'b00;
  logic [31:0] rx_flit_drv = 32'd0;
  logic        rx_hdr_drv = 1'b0;
  logic        rx_tail_drv = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] HDR_OK   = 32'hC000_0120;
  localparam logic [31:0] HDR_BADD = 32'hC024_0120;
  localparam logic [31:0] TAIL_OK  = 32'h4000_0110;

  typedef struct packed {
    logic        fire;
    logic [1:0]  valid;
    logic        hdr;
    logic        tail;
    logic [31:0] flit;
    logic        done;
  } mon_t;
  mon_t mon_q[$];

  always #5 noc_clk = ~noc_clk;

  assign sender_ready_s      = (rand_mode ? rand_bits : 2'b11) & (loop_en ? receive_ready : 2'b11);
  assign receive_valid_s     = loop_en ? (sender_valid & sender_ready_s) : rx_valid_drv;
  assign receive_flit_s      = loop_en ? sender_flit : rx_flit_drv;
  assign receive_is_header_s = loop_en ? sender_is_header : rx_hdr_drv;
  assign receive_is_tail_s   = loop_en ? sender_is_tail : rx_tail_drv;

  noc_traffic_node #(
    .X_ID(3'd0), .Y_ID(3'd0), .DEST_X_ID(3'd0), .DEST_Y_ID(3'd0),
    .PAYLOAD_FLITS(4), .PKT_COUNT(3), .VC_NUM(2), .IDLE_GAP(0)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .send_start(send_start), .rx_hold(rx_hold),
    .sender_valid(sender_valid), .sender_ready(sender_ready_s), .sender_flit(sender_flit),
    .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
    .receive_valid(receive_valid_s), .receive_ready(receive_ready), .receive_flit(receive_flit_s),
    .receive_is_header(receive_is_header_s), .receive_is_tail(receive_is_tail_s),
    .send_busy(send_busy), .send_done(send_done), .pkt_sent_cnt(pkt_sent_cnt),
    .pkt_recv_cnt(pkt_recv_cnt), .err_cnt(err_cnt)
  );

  always @(posedge noc_clk) begin
    #1;
    rand_bits <= 2'($urandom_range(0, 3));
  end

  always @(negedge noc_clk) begin
    if (mon_en) begin
      mon_q.push_back('{fire: |(sender_valid & sender_ready_s), valid: sender_valid,
                        hdr: sender_is_header, tail: sender_is_tail, flit: sender_flit, done: send_done});
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic start_burst();
    send_start = 1'b1;
    tick(1);
    send_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick(1);
      if (send_done) got = 1'b1;
    end
    check_val("send_done_seen", got, 1'b1);
    tick(3);
  endtask

  function automatic logic [34:0] exp_vec(input int idx);
    int p;
    int pos;
    logic [1:0] vc;
    p   = idx / 6;
    pos = idx % 6;
    vc  = (p % 2 == 0) ? 2'b01 : 2'b10;
    if (pos == 0) return {vc, 1'b1, 1'b0, HDR_OK};
    if (pos == 5) return {vc, 1'b0, 1'b1, TAIL_OK};
    return {vc, 1'b0, 1'b0, 16'hFFFF, 8'(p), 8'(pos - 1)};
  endfunction

  // Replays the captured sender trace: content/order of every accepted flit, stability while stalled.
  task automatic analyze(input int start, input string tag);
    int idx = 0;
    int n_done = 0;
    logic prev_hold = 1'b0;
    logic [34:0] prev = 35'd0;
    logic [34:0] vec;
    for (int i = start; i < mon_q.size(); i++) begin
      vec = {mon_q[i].valid, mon_q[i].hdr, mon_q[i].tail, mon_q[i].flit};
      if (prev_hold) check_val({tag, "_hold_stable"}, vec, prev);
      if (mon_q[i].fire) begin
        check_val($sformatf("%s_flit%0d", tag, idx), vec, exp_vec(idx));
        idx++;
      end
      if (mon_q[i].done) n_done++;
      prev_hold = (mon_q[i].valid != 2'b00) && !mon_q[i].fire;
      prev = vec;
    end
    check_val({tag, "_flit_count"}, idx, 18);
    check_val({tag, "_done_count"}, n_done, 1);
  endtask

  task automatic rx_beat(input logic [1:0] v, input logic [31:0] f, input logic h, input logic t);
    rx_valid_drv = v;
    rx_flit_drv  = f;
    rx_hdr_drv   = h;
    rx_tail_drv  = t;
    tick(1);
    rx_valid_drv = 2'b00;
    rx_flit_drv  = 32'd0;
    rx_hdr_drv   = 1'b0;
    rx_tail_drv  = 1'b0;
  endtask

  function automatic logic [31:0] dflit(input logic [7:0] seq, input logic [7:0] k);
    return {16'hFFFF, seq, k};
  endfunction

  task automatic check_counts(input string tag, input logic [15:0] s, input logic [15:0] r, input logic [15:0] e);
    check_val({tag, "_sent"}, pkt_sent_cnt, s);
    check_val({tag, "_recv"}, pkt_recv_cnt, r);
    check_val({tag, "_err"}, err_cnt, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    tick(2);
    noc_rst_n = 1'b1;
    tick(1);
    check_val("reset_outputs", {sender_valid, sender_is_header, sender_is_tail, send_busy, send_done, sender_flit},
              {2'b00, 4'b0000, 32'd0});
    check_val("reset_rx_ready", receive_ready, 2'b11);
    check_counts("reset", 16'd0, 16'd0, 16'd0);

    // 1: loopback burst, always ready
    loop_en = 1'b1;
    mon_en  = 1'b1;
    base    = mon_q.size();
    start_burst();
    check_val("first_header", {sender_valid, sender_is_header, send_busy, sender_flit}, {2'b01, 2'b11, HDR_OK});
    wait_done(100);
    analyze(base, "t1");
    check_counts("t1", 16'd3, 16'd3, 16'd0);
    check_val("t1_idle", {send_busy, sender_valid}, 3'b000);

    // 2: random backpressure
    rand_mode = 1'b1;
    base = mon_q.size();
    start_burst();
    wait_done(600);
    rand_mode = 1'b0;
    analyze(base, "t2");
    check_counts("t2", 16'd6, 16'd6, 16'd0);
    mon_en  = 1'b0;
    loop_en = 1'b0;

    // 3: two packets interleaved flit by flit on VC0/VC1
    rx_beat(2'b01, HDR_OK, 1'b1, 1'b0);
    rx_beat(2'b10, HDR_OK, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rx_beat(2'b01, dflit(8'd5, 8'(k)), 1'b0, 1'b0);
      rx_beat(2'b10, dflit(8'd6, 8'(k)), 1'b0, 1'b0);
    end
    rx_beat(2'b01, TAIL_OK, 1'b0, 1'b1);
    rx_beat(2'b10, TAIL_OK, 1'b0, 1'b1);
    tick(2);
    check_counts("t3", 16'd6, 16'd8, 16'd0);

    // 4: corrupted k, then data while idle
    rx_beat(2'b01, HDR_OK, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) rx_beat(2'b01, dflit(8'd7, (k == 2) ? 8'd3 : 8'(k)), 1'b0, 1'b0);
    tick(2);
    check_val("t4_no_early_err", err_cnt, 16'd0);
    rx_beat(2'b01, TAIL_OK, 1'b0, 1'b1);
    tick(2);
    check_counts("t4_corrupt", 16'd6, 16'd8, 16'd1);
    rx_beat(2'b10, dflit(8'd0, 8'd0), 1'b0, 1'b0);
    tick(2);
    check_counts("t4_idle_data", 16'd6, 16'd8, 16'd2);

    // 5: wrong destination, then two valids at once inside live packets
    rx_beat(2'b10, HDR_BADD, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) rx_beat(2'b10, dflit(8'd9, 8'(k)), 1'b0, 1'b0);
    tick(2);
    check_val("t5_err_before_tail", err_cnt, 16'd2);
    rx_beat(2'b10, TAIL_OK, 1'b0, 1'b1);
    tick(2);
    check_counts("t5_dest", 16'd6, 16'd8, 16'd3);
    rx_beat(2'b01, HDR_OK, 1'b1, 1'b0);
    rx_beat(2'b10, HDR_OK, 1'b1, 1'b0);
    rx_beat(2'b11, dflit(8'd1, 8'd0), 1'b0, 1'b0);
    tick(2);
    check_val("t5_multi_err", err_cnt, 16'd4);
    for (int k = 0; k < 4; k++) begin
      rx_beat(2'b01, dflit(8'd1, 8'(k)), 1'b0, 1'b0);
      rx_beat(2'b10, dflit(8'd2, 8'(k)), 1'b0, 1'b0);
    end
    rx_beat(2'b01, TAIL_OK, 1'b0, 1'b1);
    rx_beat(2'b10, TAIL_OK, 1'b0, 1'b1);
    tick(2);
    check_counts("t5_after_multi", 16'd6, 16'd10, 16'd4);
    rx_hold = 1'b1;
    tick(1);
    check_val("rx_hold_ready", receive_ready, 2'b00);
    rx_hold = 1'b0;
    tick(1);
    check_val("rx_release_ready", receive_ready, 2'b11);

    // 6: async reset mid-DATA, then clean burst
    loop_en = 1'b1;
    start_burst();
    tick(3);
    check_val("t6_mid_burst", {send_busy, sender_is_header, sender_is_tail}, 3'b100);
    #3;
    noc_rst_n = 1'b0;
    #1;
    check_val("t6_async_valid", {sender_valid, send_busy}, 3'b000);
    check_counts("t6_async", 16'd0, 16'd0, 16'd0);
    tick(2);
    noc_rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
    base = mon_q.size();
    start_burst();
    wait_done(100);
    analyze(base, "t6");
    check_counts("t6", 16'd3, 16'd3, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
